// File: rtl/keypad_pkg.sv
// Shared types, key map and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_t;

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_BS    = 4'hB;
    localparam int         MAX_VALUE = 9999;

    // Nibble {row, col} holds the key code; row 0 col 0 is the lowest nibble.
    // r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E 0 F D
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    // Index of the low bit in a one-hot-low column drive.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest-index low row; several rows low at once resolve to the lowest.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col, 2'b00} +: 4];
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan-rate divider: one-cycle o_tick every CLK_HZ/SCAN_HZ clocks.
module keypad_scan_tick #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int DIV   = ((CLK_HZ / SCAN_HZ) > 1) ? (CLK_HZ / SCAN_HZ) : 2;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running divider; the tick is registered at the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            o_tick <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= {CNT_W{1'b0}};
            o_tick <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + ONE;
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a 0..9999
// decimal entry accumulator. Optional build macro KEYPAD_AUTOREPEAT_EN adds
// auto-repeat of held digit keys. DEBOUNCE_SCANS is expected to be >= 2.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1_000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_SCANS   = 300
) (
    input  logic        sysclk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_keyRow,
    output logic [3:0]  o_keyCol,
    output logic        o_keyValid,
    output logic [3:0]  o_keyCode,
    output logic [13:0] o_value
);

    // One counter width serves both the debounce and the repeat counters.
    localparam int CNT_MAX = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_CNT     = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [16:0]      VALUE_LIMIT = 17'(MAX_VALUE);

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic             tick_s;
    kp_state_t        state_r;
    kp_state_t        state_n;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [3:0]       cand_r;
    logic [3:0]       cand_n;
    logic [3:0]       col_n;
    logic             valid_n;
    logic [3:0]       code_n;
    logic [13:0]      value_n;
    logic             accept_s;
    logic             all_high_s;
    logic [3:0]       sample_code_s;
    logic [16:0]      digit_sum_s;
    logic [13:0]      value_div_s;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_CNT = CNT_W'(REPEAT_SCANS);
    logic [CNT_W-1:0] rep_r;
    logic [CNT_W-1:0] rep_n;
    logic [CNT_W-1:0] rep_inc_s;
`endif

    keypad_scan_tick #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_tick (
        .clk    (sysclk),
        .rst_n  (i_rst_n),
        .o_tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous row inputs (idle high).
    always_ff @(posedge sysclk) begin
        if (!i_rst_n) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= i_keyRow;
            row_sync_r <= row_meta_r;
        end
    end

    assign all_high_s    = &row_sync_r;
    assign sample_code_s = key_code(first_low_row(row_sync_r), col_index(o_keyCol));
    assign cnt_inc_s     = cnt_r + CNT_ONE;
    // v*10 + d as (v<<3)+(v<<1)+d, kept in 17 bits so overflow is visible.
    assign digit_sum_s   = {o_value, 3'b000} + {2'b00, o_value, 1'b0} + {13'd0, cand_r};
    assign value_div_s   = o_value / 14'd10;
`ifdef KEYPAD_AUTOREPEAT_EN
    assign rep_inc_s     = rep_r + CNT_ONE;
`endif

    // Scan/debounce FSM next-state; everything advances only on scan ticks.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        cand_n   = cand_r;
        col_n    = o_keyCol;
        accept_s = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n    = rep_r;
`endif
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (all_high_s) begin
                        col_n = {o_keyCol[2:0], o_keyCol[3]};
                    end else begin
                        cand_n  = sample_code_s;
                        cnt_n   = CNT_ONE;
                        state_n = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (all_high_s || (sample_code_s != cand_r)) begin
                        // Bounce: re-sample the same column, no rotation.
                        state_n = SCAN;
                    end else if (cnt_inc_s == DEB_CNT) begin
                        cnt_n    = cnt_inc_s;
                        accept_s = 1'b1;
                        state_n  = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n    = {CNT_W{1'b0}};
`endif
                    end else begin
                        cnt_n = cnt_inc_s;
                    end
                end
                HELD: begin
                    if (all_high_s) begin
                        cnt_n   = CNT_ONE;
                        state_n = REL_DB;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n   = {CNT_W{1'b0}};
`endif
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (rep_inc_s == REP_CNT) begin
                            rep_n    = {CNT_W{1'b0}};
                            accept_s = is_digit(cand_r);
                        end else begin
                            rep_n = rep_inc_s;
                        end
`else
                        state_n = HELD;
`endif
                    end
                end
                REL_DB: begin
                    if (!all_high_s) begin
                        state_n = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_n   = {CNT_W{1'b0}};
`endif
                    end else if (cnt_inc_s == DEB_CNT) begin
                        cnt_n   = cnt_inc_s;
                        state_n = SCAN;
                    end else begin
                        cnt_n = cnt_inc_s;
                    end
                end
                default: begin
                    state_n = SCAN;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Accept actions: pulse, code capture and decimal entry update.
    always_comb begin
        valid_n = accept_s;
        code_n  = o_keyCode;
        value_n = o_value;
        if (accept_s) begin
            code_n = cand_r;
            case (cand_r)
                KEY_CLR: value_n = 14'd0;
                KEY_BS:  value_n = value_div_s;
                default: begin
                    if (is_digit(cand_r) && (digit_sum_s <= VALUE_LIMIT)) begin
                        value_n = digit_sum_s[13:0];
                    end else begin
                        value_n = o_value;
                    end
                end
            endcase
        end else begin
            code_n = o_keyCode;
        end
    end

    // State and output registers.
    always_ff @(posedge sysclk) begin
        if (!i_rst_n) begin
            state_r    <= SCAN;
            cnt_r      <= {CNT_W{1'b0}};
            cand_r     <= 4'd0;
            o_keyCol   <= 4'b1110;
            o_keyValid <= 1'b0;
            o_keyCode  <= 4'd0;
            o_value    <= 14'd0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            cand_r     <= cand_n;
            o_keyCol   <= col_n;
            o_keyValid <= valid_n;
            o_keyCode  <= code_n;
            o_value    <= value_n;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Repeat tick counter while a digit key stays held.
    always_ff @(posedge sysclk) begin
        if (!i_rst_n) begin
            rep_r <= {CNT_W{1'b0}};
        end else begin
            rep_r <= rep_n;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the
// rows, a behavioural model predicts every output each cycle, and directed
// checks pin key results. Honours KEYPAD_AUTOREPEAT_EN like the design.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int DEB       = 3;
    localparam int REP       = 8;
    localparam int TICK_CLKS = CLK_HZ / SCAN_HZ;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [13:0] value;
    logic [15:0] mask;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int code_log[$];

    int keymap[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    // model state
    bit         m_init = 1'b0;
    int         m_k, m_col, m_run, m_rel, m_rep, m_cand, m_code, m_value;
    bit         m_held, m_valid;
    logic [3:0] m_s1, m_s2;

    always #5 sysclk = ~sysclk;

    keypad_scanner #(
        .CLK_HZ         (CLK_HZ),
        .SCAN_HZ        (SCAN_HZ),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .sysclk     (sysclk),
        .i_rst_n    (rst_n),
        .i_keyRow   (key_row),
        .o_keyCol   (key_col),
        .o_keyValid (key_valid),
        .o_keyCode  (key_code),
        .o_value    (value)
    );

    function automatic logic [3:0] matrix_rows(input logic [15:0] m, input logic [3:0] col);
        logic [3:0] rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (m[r*4+c] && col[c] === 1'b0) rows[r] = 1'b0;
        return rows;
    endfunction

    // Physical matrix: a pressed key shorts its row to its driven-low column.
    always @* key_row = matrix_rows(mask, key_col);

    function automatic logic [15:0] key_bit(input int code);
        logic [15:0] b = 16'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keymap[r][c] == code) b = 16'h1 << (r*4+c);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_accept();
        int n;
        m_valid = 1'b1;
        m_code  = m_cand;
        if (m_cand <= 9) begin
            n = m_value * 10 + m_cand;
            if (n <= 9999) m_value = n;
        end else if (m_cand == 10) begin
            m_value = 0;
        end else if (m_cand == 11) begin
            m_value = m_value / 10;
        end
    endtask

    // Predicts the effect of the coming rising edge.
    task automatic model_step();
        logic [3:0] rows_now, fsm_rows;
        int code, low;
        bit none;
        if (rst_n !== 1'b1) begin
            m_init = 1'b1; m_k = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_col = 0;
            m_held = 1'b0; m_run = 0; m_rel = 0; m_rep = 0; m_cand = 0;
            m_code = 0; m_value = 0; m_valid = 1'b0;
        end else begin
            m_k++;
            rows_now = matrix_rows(mask, 4'hF ^ (4'h1 << m_col));
            fsm_rows = m_s2;
            m_s2 = m_s1;
            m_s1 = rows_now;
            m_valid = 1'b0;
            if (m_k > TICK_CLKS && (m_k % TICK_CLKS) == 1) begin
                none = (fsm_rows == 4'hF);
                low = 3;
                for (int r = 3; r >= 0; r--) if (fsm_rows[r] == 1'b0) low = r;
                code = none ? -1 : keymap[low][m_col];
                if (!m_held) begin
                    if (m_run == 0) begin
                        if (none) m_col = (m_col + 1) % 4;
                        else begin m_cand = code; m_run = 1; end
                    end else if (none || code != m_cand) begin
                        m_run = 0;
                    end else begin
                        m_run++;
                        if (m_run == DEB) begin
                            model_accept();
                            m_held = 1'b1; m_rel = 0; m_rep = 0;
                        end
                    end
                end else if (m_rel == 0) begin
                    if (none) begin
                        m_rel = 1; m_rep = 0;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        m_rep++;
                        if (m_rep == REP) begin
                            m_rep = 0;
                            if (m_cand <= 9) model_accept();
                        end
`endif
                    end
                end else if (none) begin
                    m_rel++;
                    if (m_rel == DEB) begin m_held = 1'b0; m_run = 0; end
                end else begin
                    m_rel = 0; m_rep = 0;
                end
            end
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge sysclk) begin
        if (m_init) begin
            check("col",   key_col,   15 ^ (1 << m_col));
            check("valid", key_valid, int'(m_valid));
            check("code",  key_code,  m_code);
            check("value", value,     m_value);
        end
        model_step();
    end

    // Pulse log taken from the DUT outputs.
    always @(negedge sysclk) begin
        if (key_valid === 1'b1) begin
            pulses++;
            code_log.push_back(int'(key_code));
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic press(input int ka, input int kb, input int hold_clks, input int rel_clks);
        mask = key_bit(ka);
        if (kb >= 0) mask = mask | key_bit(kb);
        wait_clks(hold_clks);
        mask = 16'h0;
        wait_clks(rel_clks);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst_n = 1'b0;
        mask  = 16'h0;
        // 1: reset and free rotation
        wait_clks(5);
        check("rst_col", key_col, 14);
        check("rst_value", value, 0);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        rst_n = 1'b1;
        repeat (11) @(posedge sysclk); #1;
        check("rot_1101", key_col, 13);
        repeat (10) @(posedge sysclk); #1;
        check("rot_1011", key_col, 11);
        repeat (10) @(posedge sysclk); #1;
        check("rot_0111", key_col, 7);
        #1;

        // 2: enter 1,2,3,4
        p0 = pulses;
        for (int d = 1; d <= 4; d++) press(d, -1, 10 * TICK_CLKS, 6 * TICK_CLKS);
        check("t2_pulses", pulses - p0, 4);
        for (int i = 0; i < 4; i++)
            if (code_log.size() > p0 + i) check("t2_code", code_log[p0+i], i + 1);
            else check("t2_code_missing", code_log.size(), p0 + 4);
        check("t2_value", value, 1234);
        check("t2_model_value", m_value, 1234);

        // 3: overflow hold, backspace, clear
        p0 = pulses;
        press(5, -1, 10 * TICK_CLKS, 6 * TICK_CLKS);
        check("t3_pulse5", pulses - p0, 1);
        check("t3_code5", key_code, 5);
        check("t3_value_hold", value, 1234);
        press(11, -1, 10 * TICK_CLKS, 6 * TICK_CLKS);
        check("t3_bs", value, 123);
        check("t3_model_bs", m_value, 123);
        press(10, -1, 10 * TICK_CLKS, 6 * TICK_CLKS);
        check("t3_clr", value, 0);

        // 4: bounce, long hold, two rows in one column
        p0 = pulses;
        mask = key_bit(1);
        wait_clks(2 * TICK_CLKS);
        mask = 16'h0;
        wait_clks(10 * TICK_CLKS);
        check("t4_bounce", pulses - p0, 0);
        p0 = pulses;
        press(8, -1, 40 * TICK_CLKS, 6 * TICK_CLKS);
        check("t4_code8", key_code, 8);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("t4_long_pulses", pulses - p0, 1);
        check("t4_value8", value, 8);
`endif
        press(4, 7, 10 * TICK_CLKS, 6 * TICK_CLKS);
        check("t4_lowest_row", key_code, 4);
`ifndef KEYPAD_AUTOREPEAT_EN
        check("t4_value84", value, 84);
        check("t4_model_84", m_value, 84);
`endif

        // 5: reset while 7 held
        mask = key_bit(7);
        wait_clks(10 * TICK_CLKS);
        rst_n = 1'b0;
        wait_clks(5);
        check("t5_rst_col", key_col, 14);
        check("t5_rst_value", value, 0);
        check("t5_rst_valid", key_valid, 0);
        check("t5_rst_code", key_code, 0);
        rst_n = 1'b1;
        p0 = pulses;
        wait_clks(10 * TICK_CLKS);
        check("t5_pulses", pulses - p0, 1);
        check("t5_code7", key_code, 7);
        check("t5_value7", value, 7);
        check("t5_model_7", m_value, 7);
        mask = 16'h0;
        wait_clks(6 * TICK_CLKS);

`ifdef KEYPAD_AUTOREPEAT_EN
        // 6: auto-repeat on digits only
        press(10, -1, 10 * TICK_CLKS, 6 * TICK_CLKS);
        p0 = pulses;
        press(9, -1, 23 * TICK_CLKS, 6 * TICK_CLKS);
        check("t6_rep_pulses", pulses - p0, 3);
        check("t6_value999", value, 999);
        check("t6_model_999", m_value, 999);
        p0 = pulses;
        press(10, -1, 20 * TICK_CLKS, 6 * TICK_CLKS);
        check("t6_clr_single", pulses - p0, 1);
        check("t6_value0", value, 0);
`endif

        // 7: random presses, chords, bounces and resets
        for (int it = 0; it < 30; it++) begin
            mask = key_bit(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) mask = mask | (16'h1 << $urandom_range(0, 15));
            wait_clks(int'($urandom_range(5, 150)));
            mask = 16'h0;
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                wait_clks(int'($urandom_range(1, 4)));
                rst_n = 1'b1;
            end
            wait_clks(int'($urandom_range(5, 120)));
        end

        wait_clks(50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
